lighting_ctrl: RTL and testbench

Sequencer for the `lighting` colour-cycling block. It generates that block's one-bit `button` advance input from one of three sources: a debounced manual push-button, a free-running auto-advance timer, or a seek engine that steps the colour until it equals a requested target. It observes `lighting`'s `colour` output as feedback and sits between board inputs and the `lighting` instance.

---
 rtl/lighting_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 43 ++++
 rtl/lighting_ctrl.sv | 128 ++++++++++++
 tb/tb_lighting_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lighting_pkg.sv
// Shared constants, mode encodings and seek FSM states for the lighting sequencer.
// The colour-legality helper keeps the 001..110 range definition in one place.
package lighting_pkg;

    localparam logic [2:0] COL_FIRST = 3'b001;
    localparam logic [2:0] COL_LAST  = 3'b110;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_MANUAL = 2'b01;
    localparam logic [1:0] MODE_AUTO   = 2'b10;
    localparam logic [1:0] MODE_SEEK   = 2'b11;

    localparam logic [2:0] MAX_SEEK_STEPS = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SEEK_CHECK = 2'd1,
        ST_SEEK_WAIT  = 2'd2
    } state_t;

    function automatic logic colour_legal(input logic [2:0] c);
        return (c >= COL_FIRST) && (c <= COL_LAST);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and a
// one-cycle pulse on each accepted 0-to-1 level change.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            rise  <= 1'b0;
            // Any sample agreeing with the accepted level restarts the stability run.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
                rise  <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lighting_ctrl.sv
// Advance-pulse sequencer for the lighting block: manual, auto-timer and
// seek-to-target sources muxed onto a single registered button output.
module lighting_ctrl
    import lighting_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_PERIOD     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic [1:0] mode,
    input  logic [2:0] target,
    input  logic       target_valid,
    input  logic [2:0] colour_in,
    output logic       button,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_t     state, state_nx;
    logic [1:0] mode_q;
    logic [7:0] auto_cnt, auto_nx;
    logic [2:0] step_cnt, step_nx;
    logic [2:0] tgt, tgt_nx;
    logic       bad_pend, bad_nx;
    logic       button_nx, busy_nx, done_nx, err_nx;
    logic       rise;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_raw),
        .rise (rise)
    );

    always_comb begin
        state_nx  = state;
        auto_nx   = 8'd0;
        step_nx   = step_cnt;
        tgt_nx    = tgt;
        bad_nx    = 1'b0;
        button_nx = 1'b0;
        busy_nx   = busy;
        done_nx   = 1'b0;
        err_nx    = 1'b0;
        case (state)
            ST_IDLE: begin
                busy_nx = 1'b0;
                // An illegal request is reported one cycle after its strobe.
                if (bad_pend) begin
                    done_nx = 1'b1;
                    err_nx  = 1'b1;
                end
                case (mode_q)
                    MODE_MANUAL: button_nx = rise;
                    MODE_AUTO: begin
                        if (auto_cnt == 8'(AUTO_PERIOD - 1)) begin
                            button_nx = 1'b1;
                        end else begin
                            auto_nx = auto_cnt + 8'd1;
                        end
                    end
                    MODE_SEEK: begin
                        if (target_valid) begin
                            tgt_nx = target;
                            if (colour_legal(target)) begin
                                busy_nx  = 1'b1;
                                step_nx  = 3'd0;
                                state_nx = ST_SEEK_CHECK;
                            end else begin
                                bad_nx = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            ST_SEEK_CHECK: begin
                if (colour_in == tgt) begin
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = ST_IDLE;
                end else if (!colour_legal(colour_in) || step_cnt == MAX_SEEK_STEPS) begin
                    done_nx  = 1'b1;
                    err_nx   = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = ST_IDLE;
                end else begin
                    button_nx = 1'b1;
                    step_nx   = step_cnt + 3'd1;
                    state_nx  = ST_SEEK_WAIT;
                end
            end
            // Compare only after lighting has consumed the pulse, so no overshoot.
            ST_SEEK_WAIT: state_nx = ST_SEEK_CHECK;
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_HOLD;
            auto_cnt <= 8'd0;
            step_cnt <= 3'd0;
            tgt      <= COL_FIRST;
            bad_pend <= 1'b0;
            button   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            mode_q   <= mode;
            auto_cnt <= auto_nx;
            step_cnt <= step_nx;
            tgt      <= tgt_nx;
            bad_pend <= bad_nx;
            button   <= button_nx & ~button;
            busy     <= busy_nx;
            done     <= done_nx;
            err      <= err_nx;
        end
    end

endmodule

// File: tb/tb_lighting_ctrl.sv
// Closed-loop bench: lighting_ctrl drives a behavioural lighting colour model
// whose colour feeds back into colour_in.
module tb_lighting_ctrl;
    import lighting_pkg::*;

    localparam int D      = 4;
    localparam int AUTO_P = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_raw;
    logic [1:0] mode;
    logic [2:0] target;
    logic       target_valid;
    logic [2:0] colour_in;
    logic       button, busy, done, err;

    logic [2:0] colour;
    logic       freeze, force_bad;
    logic       button_d;
    int         pulse_cnt  = 0;
    int         consec_cnt = 0;
    int         checks = 0;
    int         passed = 0;

    lighting_ctrl #(.DEBOUNCE_CYCLES(D), .AUTO_PERIOD(AUTO_P)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .mode         (mode),
        .target       (target),
        .target_valid (target_valid),
        .colour_in    (colour_in),
        .button       (button),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Behavioural lighting block: one step per edge with button high, 110 wraps to 001.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) colour <= 3'b001;
        else if (button && !freeze) colour <= (colour == 3'd6) ? 3'd1 : colour + 3'd1;
    end
    assign colour_in = force_bad ? 3'b111 : colour;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            button_d <= 1'b0;
        end else begin
            if (button) pulse_cnt <= pulse_cnt + 1;
            if (button && button_d) consec_cnt <= consec_cnt + 1;
            button_d <= button;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic set_mode(input logic [1:0] m);
        mode = m;
        tick();
        tick();
    endtask

    task automatic run_seek(input logic [2:0] tgt, output int done_cyc, output logic err_o,
                            output int pulses, output logic busy0);
        int p0;
        p0       = pulse_cnt;
        done_cyc = -1;
        err_o    = 1'bx;
        busy0    = 1'bx;
        target       = tgt;
        target_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            target_valid = 1'b0;
            if (k == 0) busy0 = busy;
            if (done) begin
                done_cyc = k;
                err_o    = err;
                break;
            end
        end
        tick();
        pulses = pulse_cnt - p0;
    endtask

    task automatic test_reset();
        int dc, np, dones;
        logic e, b0;
        repeat (3) tick();
        checks++; if (button !== 1'b0) $display("FAIL reset_button: got %b expected 0", button); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else passed++;
        rst = 1'b0;
        tick();
        set_mode(MODE_SEEK);
        target       = 3'd5;
        target_valid = 1'b1;
        tick();
        target_valid = 1'b0;
        checks++; if (busy !== 1'b1) $display("FAIL seek_busy_c0: got %b expected 1", busy); else passed++;
        tick();
        checks++; if (button !== 1'b1) $display("FAIL seek_button_c1: got %b expected 1", button); else passed++;
        // Reset lands while the FSM waits for lighting to consume the pulse.
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL async_busy: got %b expected 0", busy); else passed++;
        checks++; if (button !== 1'b0) $display("FAIL async_button: got %b expected 0", button); else passed++;
        tick();
        tick();
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done) dones++;
        end
        checks++; if (dones !== 0) $display("FAIL no_done_after_reset: got %0d expected 0", dones); else passed++;
        run_seek(3'd4, dc, e, np, b0);
        checks++; if (dc !== 7 || e !== 1'b0) $display("FAIL seek_after_reset: got cyc %0d err %b expected cyc 7 err 0", dc, e); else passed++;
    endtask

    task automatic test_manual();
        int p0, first, highs;
        do_reset();
        set_mode(MODE_MANUAL);
        p0 = pulse_cnt;
        for (int p = 0; p < 3; p++) begin
            btn_raw = 1'b1;
            first   = -1;
            highs   = 0;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (button) begin
                    highs++;
                    if (first < 0) first = k;
                end
            end
            btn_raw = 1'b0;
            repeat (12) tick();
            checks++; if (first !== D + 2) $display("FAIL manual_latency: got %0d expected %0d", first, D + 2); else passed++;
            checks++; if (highs !== 1) $display("FAIL manual_pulses_per_press: got %0d expected 1", highs); else passed++;
        end
        btn_raw = 1'b1;
        tick();
        btn_raw = 1'b0;
        repeat (12) tick();
        checks++; if (pulse_cnt - p0 !== 3) $display("FAIL manual_total: got %0d expected 3", pulse_cnt - p0); else passed++;
        checks++; if (colour !== 3'b100) $display("FAIL manual_colour: got %b expected 100", colour); else passed++;
    endtask

    task automatic test_auto();
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        logic [2:0] col49;
        int n;
        do_reset();
        for (int t = AUTO_P; t < 70; t += AUTO_P) exp_q.push_back(8'(t));
        n = exp_q.size();
        col49 = 3'b000;
        mode = MODE_AUTO;
        for (int k = 0; k < 70; k++) begin
            tick();
            if (button) got_q.push_back(8'(k));
            if (k == 49) col49 = colour;
        end
        checks++; if (got_q.size() !== exp_q.size()) $display("FAIL auto_count: got %0d expected %0d", got_q.size(), exp_q.size()); else passed++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [7:0] ex, gt;
            ex = exp_q.pop_front();
            gt = got_q.pop_front();
            checks++; if (gt !== ex) $display("FAIL auto_pulse_cycle: got %0d expected %0d", gt, ex); else passed++;
        end
        checks++; if (col49 !== 3'b001) $display("FAIL auto_wrap: got %b expected 001", col49); else passed++;
        checks++; if (colour !== 3'((n % 6) + 1)) $display("FAIL auto_colour: got %b expected %0d", colour, (n % 6) + 1); else passed++;
    endtask

    task automatic test_hold();
        int p0;
        mode = MODE_HOLD;
        tick();
        tick();
        p0 = pulse_cnt;
        for (int k = 0; k < 8; k++) begin
            btn_raw = 1'($urandom_range(0, 1));
            repeat (8) tick();
        end
        btn_raw = 1'b0;
        repeat (12) tick();
        checks++; if (pulse_cnt - p0 !== 0) $display("FAIL hold_pulses: got %0d expected 0", pulse_cnt - p0); else passed++;
    endtask

    task automatic test_seek_directed();
        int dc, np;
        logic e, b0;
        do_reset();
        set_mode(MODE_SEEK);
        run_seek(3'b011, dc, e, np, b0);
        checks++; if (dc !== 5 || e !== 1'b0) $display("FAIL seek_2step: got cyc %0d err %b expected cyc 5 err 0", dc, e); else passed++;
        run_seek(3'b010, dc, e, np, b0);
        checks++; if (dc !== 11 || e !== 1'b0) $display("FAIL seek_wrap_done: got cyc %0d err %b expected cyc 11 err 0", dc, e); else passed++;
        checks++; if (np !== 5) $display("FAIL seek_wrap_pulses: got %0d expected 5", np); else passed++;
        repeat (4) tick();
        checks++; if (colour !== 3'b010) $display("FAIL seek_wrap_colour: got %b expected 010", colour); else passed++;
        run_seek(3'b000, dc, e, np, b0);
        checks++; if (dc !== 1 || e !== 1'b1 || np !== 0 || b0 !== 1'b0)
            $display("FAIL seek_target_000: got cyc %0d err %b pulses %0d busy %b expected 1 1 0 0", dc, e, np, b0); else passed++;
        run_seek(3'b010, dc, e, np, b0);
        checks++; if (dc !== 1 || e !== 1'b0 || np !== 0) $display("FAIL seek_current: got cyc %0d err %b pulses %0d expected 1 0 0", dc, e, np); else passed++;
        run_seek(3'b111, dc, e, np, b0);
        checks++; if (dc !== 1 || e !== 1'b1) $display("FAIL seek_target_111: got cyc %0d err %b expected 1 1", dc, e); else passed++;
    endtask

    task automatic test_seek_boundaries();
        int dc, np;
        logic e, b0;
        freeze = 1'b1;
        run_seek(3'b101, dc, e, np, b0);
        freeze = 1'b0;
        checks++; if (dc !== 13 || e !== 1'b1 || np !== 6) $display("FAIL seek_max_steps: got cyc %0d err %b pulses %0d expected 13 1 6", dc, e, np); else passed++;
        force_bad = 1'b1;
        run_seek(3'b011, dc, e, np, b0);
        force_bad = 1'b0;
        checks++; if (dc !== 1 || e !== 1'b1 || np !== 0) $display("FAIL seek_bad_colour: got cyc %0d err %b pulses %0d expected 1 1 0", dc, e, np); else passed++;
    endtask

    task automatic test_seek_ignores();
        int p0, dc, start;
        logic [2:0] tgt;
        start = int'(colour);
        tgt   = 3'(((start - 1 + 4) % 6) + 1);
        target       = tgt;
        target_valid = 1'b1;
        dc = -1;
        for (int k = 0; k < 20; k++) begin
            tick();
            target_valid = 1'b0;
            if (k == 1) begin
                mode    = MODE_MANUAL;
                btn_raw = 1'b1;
            end
            if (k == 2) begin
                target       = 3'b000;
                target_valid = 1'b1;
            end
            if (done) begin
                dc = k;
                break;
            end
        end
        target_valid = 1'b0;
        checks++; if (dc !== 9 || err !== 1'b0) $display("FAIL seek_ignores_done: got cyc %0d err %b expected 9 0", dc, err); else passed++;
        p0 = pulse_cnt;
        repeat (10) tick();
        checks++; if (pulse_cnt - p0 !== 0) $display("FAIL seek_discard_edge: got %0d expected 0", pulse_cnt - p0); else passed++;
        checks++; if (colour !== tgt) $display("FAIL seek_ignores_colour: got %b expected %b", colour, tgt); else passed++;
        btn_raw = 1'b0;
        repeat (12) tick();
        set_mode(MODE_SEEK);
    endtask

    task automatic test_seek_random();
        int dc, np, t, s, steps, exp_dc, exp_np;
        logic e, b0, legal;
        logic [2:0] tgt, exp_col;
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            tgt   = 3'($urandom_range(0, 7));
            t     = int'(tgt);
            s     = int'(colour);
            legal = (t >= 1) && (t <= 6);
            steps = legal ? (t - s + 6) % 6 : 0;
            exp_dc  = legal ? 2 * steps + 1 : 1;
            exp_np  = steps;
            exp_col = legal ? tgt : colour;
            run_seek(tgt, dc, e, np, b0);
            checks++; if (dc !== exp_dc) $display("FAIL rand_done_cycle: got %0d expected %0d (target %0d)", dc, exp_dc, t); else passed++;
            checks++; if (e !== !legal) $display("FAIL rand_err: got %b expected %b (target %0d)", e, !legal, t); else passed++;
            checks++; if (np !== exp_np) $display("FAIL rand_pulses: got %0d expected %0d", np, exp_np); else passed++;
            checks++; if (b0 !== legal) $display("FAIL rand_busy: got %b expected %b", b0, legal); else passed++;
            checks++; if (colour !== exp_col) $display("FAIL rand_colour: got %b expected %b", colour, exp_col); else passed++;
        end
    endtask

    task automatic test_no_back_to_back();
        checks++; if (consec_cnt !== 0) $display("FAIL back_to_back: got %0d expected 0", consec_cnt); else passed++;
    endtask

    initial begin
        rst          = 1'b1;
        btn_raw      = 1'b0;
        mode         = MODE_HOLD;
        target       = 3'b000;
        target_valid = 1'b0;
        freeze       = 1'b0;
        force_bad    = 1'b0;
        test_reset();
        test_manual();
        test_auto();
        test_hold();
        test_seek_directed();
        test_seek_boundaries();
        test_seek_ignores();
        test_seek_random();
        test_no_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
